// File: rtl/comparador_pkg.sv
// Shared types and constants for the nibble-serial comparator controller.
// Optional feature macro: COMPARADOR_SINAL_EN (two's complement operands), used by the top.
package comparador_pkg;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        COMPARA   = 2'd1,
        RESULTADO = 2'd2
    } estado_t;

    typedef enum logic [1:0] {
        RES_IGUAL = 2'd0,
        RES_MAIOR = 2'd1,
        RES_MENOR = 2'd2
    } resultado_t;

    localparam int NIBBLE_W = 4;

endpackage

// File: rtl/comparador_nibble.sv
// Combinational 4-bit comparator slice; exactly one of eq/gt/lt is high.
module comparador_nibble
    import comparador_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    output logic                eq,
    output logic                gt,
    output logic                lt
);

    // Unsigned magnitude compare of one nibble
    always_comb begin
        eq = (x == y);
        gt = (x > y);
        lt = (x < y);
    end

endmodule

// File: rtl/comparador_serial_ctrl.sv
// Nibble-serial comparator controller: latches two LARGURA-bit operands, scans
// them MSB nibble first with a single comparator slice, stops at the first
// unequal nibble and holds the result until the consumer takes it.
// Optional feature macro: COMPARADOR_SINAL_EN -- operands are two's complement;
// a sign mismatch decides the result in the first compare cycle.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// OCIOSO    | idle, in_ready=1, waiting for an operand pair
// COMPARA   | one nibble examined per cycle, idx walks from MSB nibble down
// RESULTADO | out_valid=1, flags and nibble count held until out_ready
module comparador_serial_ctrl
    import comparador_pkg::*;
#(
    parameter int LARGURA = 16
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [LARGURA-1:0]                       a,
    input  logic [LARGURA-1:0]                       b,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic                                     iguais,
    output logic                                     maior,
    output logic                                     menor,
    output logic [$clog2(LARGURA/NIBBLE_W+1)-1:0]    nibbles_usados
);

    localparam int NIBBLES = LARGURA / NIBBLE_W;
    localparam int CW      = $clog2(NIBBLES + 1);
    localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    if ((LARGURA % NIBBLE_W) != 0 || LARGURA < NIBBLE_W) begin : g_largura_invalida
        $error("comparador_serial_ctrl: LARGURA must be a positive multiple of 4");
    end

    estado_t               estado_q, estado_d;
    resultado_t            res_q, res_d;
    logic [LARGURA-1:0]    a_q, a_d;
    logic [LARGURA-1:0]    b_q, b_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         count_q, count_d;

    logic [NIBBLE_W-1:0]   nib_a, nib_b;
    logic                  nib_eq, nib_gt, nib_lt;
    logic                  decide_sinal;

    // Select the nibble under examination; out-of-range idx values map to zero
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) begin
                nib_a = a_q[i*NIBBLE_W +: NIBBLE_W];
                nib_b = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    comparador_nibble u_nibble (
        .x  (nib_a),
        .y  (nib_b),
        .eq (nib_eq),
        .gt (nib_gt),
        .lt (nib_lt)
    );

`ifdef COMPARADOR_SINAL_EN
    // Signed mode: differing sign bits settle the result on the first compare cycle
    always_comb begin
        decide_sinal = (count_q == '0) && (a_q[LARGURA-1] != b_q[LARGURA-1]);
    end
`else
    // Unsigned mode: the sign shortcut is absent
    always_comb begin
        decide_sinal = 1'b0;
    end
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= OCIOSO;
            res_q    <= RES_IGUAL;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            count_q  <= '0;
        end else begin
            estado_q <= estado_d;
            res_q    <= res_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        estado_d = estado_q;
        res_d    = res_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        count_d  = count_q;
        case (estado_q)
            OCIOSO: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    idx_d    = IW'(NIBBLES - 1);
                    count_d  = '0;
                    estado_d = COMPARA;
                end
            end
            COMPARA: begin
                count_d = count_q + CW'(1);
                if (decide_sinal) begin
                    res_d    = a_q[LARGURA-1] ? RES_MENOR : RES_MAIOR;
                    estado_d = RESULTADO;
                end else if (!nib_eq) begin
                    res_d    = nib_gt ? RES_MAIOR : (nib_lt ? RES_MENOR : RES_IGUAL);
                    estado_d = RESULTADO;
                end else if (idx_q == '0) begin
                    res_d    = RES_IGUAL;
                    estado_d = RESULTADO;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            RESULTADO: begin
                if (out_ready) begin
                    res_d    = RES_IGUAL;
                    count_d  = '0;
                    estado_d = OCIOSO;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // Outputs are gated by state so flags and count read zero outside RESULTADO
    always_comb begin
        in_ready       = (estado_q == OCIOSO);
        out_valid      = (estado_q == RESULTADO);
        iguais         = out_valid && (res_q == RES_IGUAL);
        maior          = out_valid && (res_q == RES_MAIOR);
        menor          = out_valid && (res_q == RES_MENOR);
        nibbles_usados = out_valid ? count_q : '0;
    end

endmodule
